// File: rtl/attempt_checker_if.sv
// rtl/attempt_checker_if.sv - switch/button inputs and result outputs of attempt_checker
//
// Purpose : bundles the game-side signals of the attempt checker.
// Ports   : sw, submit (driven by master); correct, result_valid, tries_left,
//           armed, disarmed, exploded, timeout (driven by slave).
// Modports: master = switch/button side and result consumer, slave = attempt_checker.

interface attempt_checker_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] sw;
    logic             submit;
    logic [WIDTH-1:0] correct;
    logic             result_valid;
    logic [3:0]       tries_left;
    logic             armed;
    logic             disarmed;
    logic             exploded;
    logic             timeout;

    modport master (
        output sw, submit,
        input  correct, result_valid, tries_left, armed, disarmed, exploded, timeout
    );

    modport slave (
        input  sw, submit,
        output correct, result_valid, tries_left, armed, disarmed, exploded, timeout
    );
endinterface

// File: rtl/attempt_checker.sv
// rtl/attempt_checker.sv - secret capture, guess compare and tries tracking for the defusal game
//
// Purpose : captures the secret from the switches in SETUP, then compares up to
//           MAX_TRIES guesses against it and reports a per-bit match vector.
// Ports   : clk           system clock
//           rst           asynchronous active-high reset
//           bus (slave)   sw / submit in; correct, result_valid, tries_left,
//                         armed, disarmed, exploded, timeout out
// Option  : define ATTEMPT_TIMEOUT_EN to enable the per-attempt timeout of
//           TIMEOUT_CYCLES clocks; otherwise timeout is tied low.

module attempt_checker #(
    parameter int               WIDTH          = 7,
    parameter int               MAX_TRIES      = 3,
    parameter logic [WIDTH-1:0] SECRET_RST     = 7'b1011001,
    parameter int unsigned      TIMEOUT_CYCLES = 500_000_000
) (
    input  logic               clk,
    input  logic               rst,
    attempt_checker_if.slave   bus
);

    typedef enum logic [2:0] {
        SETUP,
        ARMED,
        CHECK,
        DISARMED,
        EXPLODED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] secret_q;
    logic [WIDTH-1:0] guess_q;
    logic [WIDTH-1:0] correct_q;
    logic             result_valid_q;
    logic [3:0]       tries_q;

    logic s1_q, s2_q, s3_q;
    logic sp;

    logic load_secret;
    logic load_guess;
    logic do_compare;
    logic dec_tries;
    logic fire_timeout;

    // Submit synchroniser plus one extra stage for rising-edge detection:
    // a held button yields a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.submit;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sp = s2_q & ~s3_q;

`ifdef ATTEMPT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Counts only while ARMED; any cycle outside ARMED leaves it at zero, so every
    // entry into ARMED starts from zero. An expiry also restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == ARMED && !fire_timeout) ? cnt_q + 1'b1 : '0;
            timeout_q <= fire_timeout;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SETUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_secret  = 1'b0;
        load_guess   = 1'b0;
        do_compare   = 1'b0;
        dec_tries    = 1'b0;
        fire_timeout = 1'b0;
        case (state_q)
            SETUP: begin
                if (sp) begin
                    load_secret = 1'b1;
                    state_d     = ARMED;
                end
            end
            ARMED: begin
                // A submit in the expiry cycle takes priority over the timeout.
                if (sp) begin
                    load_guess = 1'b1;
                    state_d    = CHECK;
                end
`ifdef ATTEMPT_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    fire_timeout = 1'b1;
                    dec_tries    = 1'b1;
                    state_d      = (tries_q <= 4'd1) ? EXPLODED : ARMED;
                end
`endif
            end
            CHECK: begin
                do_compare = 1'b1;
                if (guess_q == secret_q) begin
                    state_d = DISARMED;
                end else begin
                    dec_tries = 1'b1;
                    state_d   = (tries_q <= 4'd1) ? EXPLODED : ARMED;
                end
            end
            default: begin
                // DISARMED / EXPLODED are terminal; submits are dropped.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secret_q       <= SECRET_RST;
            guess_q        <= '0;
            correct_q      <= '0;
            result_valid_q <= 1'b0;
            tries_q        <= 4'(MAX_TRIES);
        end else begin
            if (load_secret) begin
                secret_q <= bus.sw;
            end
            if (load_guess) begin
                guess_q <= bus.sw;
            end
            if (do_compare) begin
                correct_q <= ~(guess_q ^ secret_q);
            end
            result_valid_q <= do_compare;
            if (dec_tries && tries_q != 4'd0) begin
                tries_q <= tries_q - 4'd1;
            end
        end
    end

    assign bus.correct      = correct_q;
    assign bus.result_valid = result_valid_q;
    assign bus.tries_left   = tries_q;
    assign bus.armed        = (state_q == ARMED) || (state_q == CHECK);
    assign bus.disarmed     = (state_q == DISARMED);
    assign bus.exploded     = (state_q == EXPLODED);

endmodule

// File: tb/tb_attempt_checker.sv
// tb/tb_attempt_checker.sv - self-checking bench for attempt_checker

module tb_attempt_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    attempt_checker_if #(.WIDTH(7)) bus();

    attempt_checker #(
        .WIDTH(7),
        .MAX_TRIES(3),
        .SECRET_RST(7'b1011001),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int rv_count = 0;
    int to_count = 0;

    // Pulse counters sampled mid-cycle, well away from both clock edges.
    always @(posedge clk) begin
        #3;
        if (bus.result_valid === 1'b1) rv_count++;
        if (bus.timeout === 1'b1) to_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.submit = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a negedge; returns on a negedge with the compare fully settled.
    task automatic press(input logic [6:0] v, input int hold);
        bus.sw = v;
        bus.submit = 1'b1;
        repeat (hold) @(negedge clk);
        bus.submit = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [6:0] secret;
        logic [6:0] guess;
        logic [6:0] exp_correct;
        logic [3:0] exp_tries;
        logic       exp_armed;
        logic       exp_disarmed;
    } vec_t;

    vec_t tbl[6];

    // Reference model: game phase plus remembered values.
    localparam int P_SETUP = 0, P_ARMED = 1, P_DISARMED = 2, P_EXPLODED = 3;
    int         m_phase;
    logic [6:0] m_secret;
    logic [6:0] m_correct;
    int         m_tries;

    function automatic logic [6:0] match_bits(input logic [6:0] g, input logic [6:0] s);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = (g[i] == s[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_phase   = P_SETUP;
        m_secret  = 7'b1011001;
        m_correct = 7'd0;
        m_tries   = 3;
    endtask

    task automatic model_press(input logic [6:0] v, output int exp_rv);
        exp_rv = 0;
        if (m_phase == P_SETUP) begin
            m_secret = v;
            m_phase  = P_ARMED;
        end else if (m_phase == P_ARMED) begin
            exp_rv    = 1;
            m_correct = match_bits(v, m_secret);
            if (m_correct == 7'h7f) begin
                m_phase = P_DISARMED;
            end else begin
                m_tries = m_tries - 1;
                if (m_tries == 0) m_phase = P_EXPLODED;
            end
        end
    endtask

    initial begin
        int r0, t0, k, hold, exp_rv;
        logic [6:0] v;

        rst = 1'b1;
        bus.sw = 7'd0;
        bus.submit = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_correct", bus.correct, 7'd0);
        chk("rst_tries", bus.tries_left, 4'd3);
        chk("rst_armed", bus.armed, 1'b0);
        chk("rst_disarmed", bus.disarmed, 1'b0);
        chk("rst_exploded", bus.exploded, 1'b0);
        chk("rst_rv", bus.result_valid, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        rst = 1'b0;

        // Setup press latency
        bus.sw = 7'b0101010;
        bus.submit = 1'b1;
        repeat (2) @(negedge clk);
        chk("setup_armed_e2", bus.armed, 1'b0);
        @(negedge clk);
        chk("setup_armed_e3", bus.armed, 1'b1);
        @(negedge clk);
        chk("setup_armed_e4", bus.armed, 1'b1);
        bus.submit = 1'b0;
        repeat (4) @(negedge clk);

        // Guess latency: result on the 4th edge that sees submit high
        bus.sw = 7'b0101101;
        bus.submit = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_rv_e3", bus.result_valid, 1'b0);
        chk("lat_correct_e3", bus.correct, 7'd0);
        @(negedge clk);
        chk("lat_rv_e4", bus.result_valid, 1'b1);
        chk("lat_correct_e4", bus.correct, 7'b1111000);
        chk("lat_tries_e4", bus.tries_left, 4'd2);
        @(negedge clk);
        chk("lat_rv_e5", bus.result_valid, 1'b0);
        bus.submit = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven single-guess vectors
        tbl[0] = '{7'b0101010, 7'b0101010, 7'b1111111, 4'd3, 1'b0, 1'b1};
        tbl[1] = '{7'b0101010, 7'b0101101, 7'b1111000, 4'd2, 1'b1, 1'b0};
        tbl[2] = '{7'b1011001, 7'b0100110, 7'b0000000, 4'd2, 1'b1, 1'b0};
        tbl[3] = '{7'b1111111, 7'b1111110, 7'b1111110, 4'd2, 1'b1, 1'b0};
        tbl[4] = '{7'b0000000, 7'b0000000, 7'b1111111, 4'd3, 1'b0, 1'b1};
        tbl[5] = '{7'b1100110, 7'b1010101, 7'b1001100, 4'd2, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            press(tbl[i].secret, 1);
            r0 = rv_count;
            press(tbl[i].guess, 2);
            chk($sformatf("tbl%0d_correct", i), bus.correct, tbl[i].exp_correct);
            chk($sformatf("tbl%0d_tries", i), bus.tries_left, tbl[i].exp_tries);
            chk($sformatf("tbl%0d_armed", i), bus.armed, tbl[i].exp_armed);
            chk($sformatf("tbl%0d_disarmed", i), bus.disarmed, tbl[i].exp_disarmed);
            chk($sformatf("tbl%0d_rv_pulses", i), rv_count - r0, 1);
        end

        // Explosion after three wrong guesses, fourth press ignored
        do_reset();
        press(7'b0110011, 1);
        r0 = rv_count;
        press(7'b0110010, 1);
        chk("exp_tries1", bus.tries_left, 4'd2);
        press(7'b1110011, 1);
        chk("exp_tries2", bus.tries_left, 4'd1);
        chk("exp_armed2", bus.armed, 1'b1);
        press(7'b0000000, 1);
        chk("exp_tries3", bus.tries_left, 4'd0);
        chk("exp_exploded", bus.exploded, 1'b1);
        chk("exp_armed3", bus.armed, 1'b0);
        chk("exp_correct3", bus.correct, 7'b1001100);
        press(7'b0110011, 3);
        chk("exp_post_correct", bus.correct, 7'b1001100);
        chk("exp_post_exploded", bus.exploded, 1'b1);
        chk("exp_post_disarmed", bus.disarmed, 1'b0);
        chk("exp_post_tries", bus.tries_left, 4'd0);
        chk("exp_rv_pulses", rv_count - r0, 3);

        // Held button: a single result
        do_reset();
        press(7'b1010101, 1);
        r0 = rv_count;
        press(7'b1010101, 1000);
        chk("held_rv_pulses", rv_count - r0, 1);
        chk("held_disarmed", bus.disarmed, 1'b1);
        chk("held_correct", bus.correct, 7'h7f);

        // Reset during CHECK
        do_reset();
        press(7'b1010101, 1);
        bus.sw = 7'b0001111;
        bus.submit = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_armed_check", bus.armed, 1'b1);
        chk("mid_rv_pre", bus.result_valid, 1'b0);
        rst = 1'b1;
        bus.submit = 1'b0;
        #1;
        chk("mid_rst_correct", bus.correct, 7'd0);
        chk("mid_rst_armed", bus.armed, 1'b0);
        chk("mid_rst_tries", bus.tries_left, 4'd3);
        chk("mid_rst_rv", bus.result_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_after_setup", bus.armed, 1'b0);
        chk("mid_after_correct", bus.correct, 7'd0);

`ifdef ATTEMPT_TIMEOUT_EN
        // Idle timeout 20 cycles after re-entering ARMED, then sp beats expiry
        do_reset();
        press(7'b0101010, 1);
        bus.sw = 7'b0101101;
        bus.submit = 1'b1;
        repeat (4) @(negedge clk);
        chk("to_guess_rv", bus.result_valid, 1'b1);
        chk("to_guess_tries", bus.tries_left, 4'd2);
        bus.submit = 1'b0;
        t0 = to_count;
        k = 0;
        while (bus.timeout !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_delay", k, 20);
        chk("to_tries", bus.tries_left, 4'd1);
        chk("to_correct", bus.correct, 7'b1111000);
        chk("to_rv", bus.result_valid, 1'b0);
        chk("to_armed", bus.armed, 1'b1);
        repeat (17) @(negedge clk);
        bus.sw = 7'b0101010;
        bus.submit = 1'b1;
        repeat (3) @(negedge clk);
        chk("coin_timeout", bus.timeout, 1'b0);
        chk("coin_tries", bus.tries_left, 4'd1);
        @(negedge clk);
        chk("coin_rv", bus.result_valid, 1'b1);
        chk("coin_correct", bus.correct, 7'h7f);
        bus.submit = 1'b0;
        @(negedge clk);
        chk("coin_disarmed", bus.disarmed, 1'b1);
        chk("coin_to_pulses", to_count - t0, 1);
`endif

        // Randomised games against the reference model
        do_reset();
        model_reset();
        t0 = to_count;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
                model_reset();
                chk("rnd_rst_correct", bus.correct, 7'd0);
                chk("rnd_rst_tries", bus.tries_left, 4'd3);
            end else begin
                hold = $urandom_range(1, 5);
                v = 7'($urandom);
                if (m_phase == P_ARMED && $urandom_range(0, 2) == 0) v = m_secret;
                r0 = rv_count;
                press(v, hold);
                model_press(v, exp_rv);
                chk("rnd_correct", bus.correct, m_correct);
                chk("rnd_tries", bus.tries_left, m_tries);
                chk("rnd_armed", bus.armed, m_phase == P_ARMED);
                chk("rnd_disarmed", bus.disarmed, m_phase == P_DISARMED);
                chk("rnd_exploded", bus.exploded, m_phase == P_EXPLODED);
                chk("rnd_rv_pulses", rv_count - r0, exp_rv);
            end
        end
        chk("rnd_no_timeouts", to_count - t0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
